// File: rtl/idst7_pkg.sv
// Shared types, constants and helpers for the 4-point inverse DST-VII datapath.
package idst7_pkg;

   localparam int unsigned N_PT   = 4;
   localparam int unsigned CNT_W  = 2;
   localparam int unsigned COEF_W = 16;
   localparam int unsigned MAT_W  = 8;
   localparam int unsigned PROD_W = 23;
   localparam int unsigned ACC_W  = 25;

   typedef logic signed [COEF_W-1:0] coef_t;
   typedef logic signed [MAT_W-1:0]  mat_t;
   typedef logic signed [PROD_W-1:0] prod_t;
   typedef logic signed [ACC_W-1:0]  acc_t;

   // C0 lands in the top bits of the bus, x0 in the bottom bits.
   typedef struct packed {
      coef_t c0;
      coef_t c1;
      coef_t c2;
      coef_t c3;
   } coef_vec_t;

   typedef struct packed {
      coef_t x3;
      coef_t x2;
      coef_t x1;
      coef_t x0;
   } res_vec_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Row k holds the weights applied to coefficient C[k] for outputs x0..x3.
   localparam mat_t DST7_M [N_PT][N_PT] = '{
      '{ 8'sd29,  8'sd55,  8'sd74,  8'sd84},
      '{ 8'sd74,  8'sd74,  8'sd0,  -8'sd74},
      '{ 8'sd84, -8'sd29, -8'sd74,  8'sd55},
      '{ 8'sd55, -8'sd84,  8'sd74, -8'sd29}
   };

   localparam acc_t CLIP_MAX = acc_t'(32767);
   localparam acc_t CLIP_MIN = acc_t'(-32768);

   function automatic coef_t clip16(input acc_t v);
      if (v > CLIP_MAX) begin
         return coef_t'(32767);
      end
      if (v < CLIP_MIN) begin
         return coef_t'(-32768);
      end
      return coef_t'(v);
   endfunction

endpackage

// File: rtl/idst7_4_seq_if.sv
// Valid/ready coefficient-in and residual-out bus of the inverse DST-VII block.
interface idst7_4_seq_if;
   import idst7_pkg::*;

   logic      in_valid;
   logic      in_ready;
   coef_vec_t coef;
   logic      out_valid;
   logic      out_ready;
   res_vec_t  res;

   modport master (
      output in_valid,
      output coef,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  res
   );

   modport slave (
      input  in_valid,
      input  coef,
      input  out_ready,
      output in_ready,
      output out_valid,
      output res
   );

endinterface

// File: rtl/idst7_4_row_mac.sv
// One matrix row per call: adds M[cnt][n]*C[cnt] to each of the four accumulators.
module idst7_4_row_mac
   import idst7_pkg::*;
(
   input  logic [CNT_W-1:0] cnt,
   input  coef_t            c_in,
   input  acc_t             acc_i [N_PT],
   output acc_t             acc_o [N_PT]
);

   prod_t prod [N_PT];

   // |C| <= 2^15 and |M| <= 84, so the 23-bit product is exact.
   for (genvar n = 0; n < N_PT; n++) begin : g_col
      assign prod[n]  = prod_t'(c_in) * prod_t'(DST7_M[cnt][n]);
      assign acc_o[n] = acc_i[n] + acc_t'(prod[n]);
   end

endmodule

// File: rtl/idst7_4_seq.sv
// Sequential 4-point inverse DST-VII: one matrix row per cycle, then round, shift and clip.
module idst7_4_seq
   import idst7_pkg::*;
#(
   parameter int unsigned SHIFT = 7
) (
   input  logic         clk,
   input  logic         rst_n,
   idst7_4_seq_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_PT - 1);
   localparam acc_t             RND      = acc_t'(1 << (SHIFT - 1));

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   coef_vec_t         coef_q, coef_d;
   acc_t              acc_q [N_PT];
   acc_t              acc_d [N_PT];
   acc_t              acc_nxt [N_PT];
   res_vec_t          res_q, res_d;
   logic              out_valid_q, out_valid_d;

   logic              in_ready_c;
   logic              accept_c;
   coef_t             c_sel_c;
   coef_t             x_c [N_PT];

   // Coefficient feeding the row selected by the cycle counter.
   always_comb begin
      c_sel_c = coef_q.c3;
      case (cnt_q)
         2'd0:    c_sel_c = coef_q.c0;
         2'd1:    c_sel_c = coef_q.c1;
         2'd2:    c_sel_c = coef_q.c2;
         default: c_sel_c = coef_q.c3;
      endcase
   end

   idst7_4_row_mac u_row_mac (
      .cnt   (cnt_q),
      .c_in  (c_sel_c),
      .acc_i (acc_q),
      .acc_o (acc_nxt)
   );

   // Rounding add stays at accumulator width; the shift is arithmetic (floor).
   for (genvar n = 0; n < N_PT; n++) begin : g_round
      assign x_c[n] = clip16((acc_nxt[n] + RND) >>> SHIFT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               state_d = ST_MAC;
            end
         end
         ST_MAC: begin
            if (cnt_q == CNT_LAST) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            // A fresh vector taken on the release edge skips IDLE entirely.
            if (bus.out_ready) begin
               state_d = bus.in_valid ? ST_MAC : ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready_c  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
      accept_c    = bus.in_valid && in_ready_c;

      coef_d      = coef_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      res_d       = res_q;
      out_valid_d = out_valid_q;

      if (state_q == ST_MAC) begin
         acc_d = acc_nxt;
         cnt_d = cnt_q + CNT_W'(1);
         if (cnt_q == CNT_LAST) begin
            res_d       = '{x3: x_c[3], x2: x_c[2], x1: x_c[1], x0: x_c[0]};
            out_valid_d = 1'b1;
         end
      end

      if ((state_q == ST_DONE) && bus.out_ready) begin
         out_valid_d = 1'b0;
      end

      if (accept_c) begin
         coef_d = bus.coef;
         cnt_d  = '0;
         acc_d  = '{default: '0};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         coef_q      <= '0;
         acc_q       <= '{default: '0};
         res_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         coef_q      <= coef_d;
         acc_q       <= acc_d;
         res_q       <= res_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_q;
   assign bus.res       = res_q;

endmodule
